bpsk_frame_decoder: RTL and testbench

//  Parametrised successor to the single-sample BPSK squitter decoder. On a preamble trigger it

---
 rtl/bpsk_pkg.sv | 14 +
 rtl/bpsk_frame_decoder_if.sv | 15 +
 rtl/bpsk_symbol_integrator.sv | 50 +++++
 rtl/bpsk_frame_decoder.sv | 128 ++++++++++++
 tb/tb_bpsk_frame_decoder.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/bpsk_pkg.sv
// rtl/bpsk_pkg.sv - shared FSM state type and trigger bit positions for the BPSK frame decoder
package bpsk_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        INTEGRATE,
        EMIT
    } state_t;

    localparam int TRIG_STROBE = 0;
    localparam int TRIG_POL    = 1;

endpackage

// File: rtl/bpsk_frame_decoder_if.sv
// rtl/bpsk_frame_decoder_if.sv - AXI-Stream style beat bundle used for sample input and frame output
interface bpsk_frame_decoder_if #(
    parameter int W = 16
);
    localparam int SW = (W + 7) / 8;

    logic          tvalid;
    logic          tready;
    logic [W-1:0]  tdata;
    logic          tlast;
    logic [SW-1:0] tstrb;

    modport master (output tvalid, output tdata, output tlast, output tstrb, input tready);
    modport slave  (input tvalid, input tdata, input tlast, input tstrb, output tready);
endinterface

// File: rtl/bpsk_symbol_integrator.sv
// rtl/bpsk_symbol_integrator.sv - integrate-and-dump over SPS valid samples with sign slicer
module bpsk_symbol_integrator #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int SPS          = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    en,
    input  logic [SAMPLE_WIDTH-1:0] sample,
    input  logic                    pol,
    output logic                    dump,
    output logic                    bit_out
);
    localparam int ACC_W = SAMPLE_WIDTH + $clog2(SPS) + 1;
    localparam int CNT_W = (SPS > 1) ? $clog2(SPS) : 1;

    logic [ACC_W-1:0] acc_q, acc_d, sum;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Sum includes the current sample so the dump cycle decides on all SPS samples.
    assign sum     = acc_q + {{(ACC_W-SAMPLE_WIDTH){sample[SAMPLE_WIDTH-1]}}, sample};
    assign dump    = en && (cnt_q == CNT_W'(SPS - 1));
    assign bit_out = ~sum[ACC_W-1] ^ pol;

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (dump) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (en) begin
            acc_d = sum;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/bpsk_frame_decoder.sv
// rtl/bpsk_frame_decoder.sv - triggered BPSK symbol decoder packing FRAME_BITS bits per output beat
module bpsk_frame_decoder
    import bpsk_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 16,
    parameter int SPS          = 8,
    parameter int FRAME_BITS   = 128,
    parameter int DELAY_WIDTH  = 16,
    parameter int DROP_WIDTH   = 16
) (
    input  logic                   s00_axis_aclk,
    input  logic                   s00_axis_aresetn,
    bpsk_frame_decoder_if.slave    s00_axis,
    input  logic [1:0]             trigger,
    input  logic [DELAY_WIDTH-1:0] start_delay,
    bpsk_frame_decoder_if.master   m00_axis,
    output logic [DROP_WIDTH-1:0]  dropped_frames,
    output logic                   busy
);
    localparam int BIT_W = $clog2(FRAME_BITS + 1);

    state_t                 state_q, state_d;
    logic [DELAY_WIDTH-1:0] dly_q, dly_d;
    logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0]  shift_q, shift_d;
    logic                   pol_q, pol_d;
    logic                   m_valid_q, m_valid_d;
    logic [FRAME_BITS-1:0]  m_data_q, m_data_d;
    logic [DROP_WIDTH-1:0]  drop_q, drop_d;
    logic                   sym_dump, sym_bit;
    logic                   unused_s00;

    bpsk_symbol_integrator #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .SPS          (SPS)
    ) u_integrator (
        .clk     (s00_axis_aclk),
        .rst_n   (s00_axis_aresetn),
        .clear   (state_q != INTEGRATE),
        .en      ((state_q == INTEGRATE) && s00_axis.tvalid),
        .sample  (s00_axis.tdata),
        .pol     (pol_q),
        .dump    (sym_dump),
        .bit_out (sym_bit)
    );

    always_comb begin
        state_d   = state_q;
        dly_d     = dly_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        pol_d     = pol_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        drop_d    = drop_q;

        case (state_q)
            IDLE: begin
                if (trigger[TRIG_STROBE]) begin
                    pol_d     = trigger[TRIG_POL];
                    dly_d     = start_delay;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                    state_d   = (start_delay != '0) ? DELAY : INTEGRATE;
                end
            end
            DELAY: begin
                if (s00_axis.tvalid) begin
                    if (dly_q == DELAY_WIDTH'(1)) state_d = INTEGRATE;
                    else                          dly_d   = dly_q - DELAY_WIDTH'(1);
                end
            end
            INTEGRATE: begin
                if (sym_dump) begin
                    shift_d   = {shift_q[FRAME_BITS-2:0], sym_bit};
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == BIT_W'(FRAME_BITS - 1)) state_d = EMIT;
                end
            end
            EMIT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (m_valid_q && m00_axis.tready) m_valid_d = 1'b0;

        // A frame still waiting on downstream is never overwritten; the new one is counted as lost.
        if (state_q == EMIT) begin
            if (!m_valid_q || m00_axis.tready) begin
                m_data_d  = shift_q;
                m_valid_d = 1'b1;
            end else if (drop_q != {DROP_WIDTH{1'b1}}) begin
                drop_d = drop_q + DROP_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            state_q   <= IDLE;
            dly_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            pol_q     <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            dly_q     <= dly_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            pol_q     <= pol_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            drop_q    <= drop_d;
        end
    end

    assign s00_axis.tready = 1'b1;
    assign unused_s00      = &{1'b0, s00_axis.tlast, s00_axis.tstrb};

    assign m00_axis.tvalid = m_valid_q;
    assign m00_axis.tdata  = m_data_q;
    assign m00_axis.tlast  = m_valid_q;
    assign m00_axis.tstrb  = '1;
    assign dropped_frames  = drop_q;
    assign busy            = (state_q != IDLE);
endmodule

// File: tb/tb_bpsk_frame_decoder.sv
// tb/tb_bpsk_frame_decoder.sv - directed-vector bench for bpsk_frame_decoder (SPS=4 and SPS=1 builds)
module tb_bpsk_frame_decoder;

    typedef int frame_t[32];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  trig, trig1;
    logic [15:0] dly, dly1;
    logic [15:0] drop, drop1;
    logic        busy, busy1;
    int          n_vec = 0;
    int          n_miss = 0;
    logic [7:0]  data;
    int          lat;
    frame_t      f;

    always #5 clk = ~clk;

    bpsk_frame_decoder_if #(.W(16)) s_if  ();
    bpsk_frame_decoder_if #(.W(8))  m_if  ();
    bpsk_frame_decoder_if #(.W(16)) s1_if ();
    bpsk_frame_decoder_if #(.W(8))  m1_if ();

    bpsk_frame_decoder #(
        .SAMPLE_WIDTH (16), .SPS (4), .FRAME_BITS (8), .DELAY_WIDTH (16), .DROP_WIDTH (16)
    ) dut (
        .s00_axis_aclk    (clk),
        .s00_axis_aresetn (rst_n),
        .s00_axis         (s_if),
        .trigger          (trig),
        .start_delay      (dly),
        .m00_axis         (m_if),
        .dropped_frames   (drop),
        .busy             (busy)
    );

    bpsk_frame_decoder #(
        .SAMPLE_WIDTH (16), .SPS (1), .FRAME_BITS (8), .DELAY_WIDTH (16), .DROP_WIDTH (16)
    ) dut1 (
        .s00_axis_aclk    (clk),
        .s00_axis_aresetn (rst_n),
        .s00_axis         (s1_if),
        .trigger          (trig1),
        .start_delay      (dly1),
        .m00_axis         (m1_if),
        .dropped_frames   (drop1),
        .busy             (busy1)
    );

    task automatic expect_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int d);
        s_if.tvalid  = v;
        s_if.tdata   = 16'(d);
        s1_if.tvalid = v;
        s1_if.tdata  = 16'(d);
        tick();
    endtask

    function automatic frame_t mk(input logic [7:0] b);
        frame_t r;
        for (int k = 0; k < 32; k++) r[k] = b[7 - k / 4] ? 100 : -100;
        return r;
    endfunction

    task automatic run_frame(input frame_t fr, input logic pol, input int delay,
                             input bit gap, input bit retrig, input int nsym);
        dly  = 16'(delay);
        trig = {pol, 1'b1};
        drive(1'b0, 0);
        trig = retrig ? 2'b11 : 2'b00;
        for (int i = 0; i < delay; i++) drive(1'b1, -5000);
        for (int i = 0; i < nsym * 4; i++) begin
            drive(1'b1, fr[i]);
            if (gap && i != nsym * 4 - 1) drive(1'b0, 20000);
        end
        trig = 2'b00;
    endtask

    // Waits for the frame beat, checks it and lets the handshake complete.
    task automatic wait_frame(output logic [7:0] d, output int n);
        n = 0;
        while (!m_if.tvalid && n < 20) begin
            tick();
            n++;
        end
        expect_eq("frame_tvalid", m_if.tvalid, 1'b1);
        expect_eq("frame_tlast", m_if.tlast, 1'b1);
        d = m_if.tdata;
        tick();
    endtask

    initial begin
        trig = 2'b00; trig1 = 2'b00; dly = 16'd0; dly1 = 16'd0;
        s_if.tvalid = 1'b0;  s_if.tdata = '0;  s_if.tlast = 1'b0;  s_if.tstrb = '0;
        s1_if.tvalid = 1'b0; s1_if.tdata = '0; s1_if.tlast = 1'b0; s1_if.tstrb = '0;
        m_if.tready = 1'b1;  m1_if.tready = 1'b1;
        repeat (3) tick();

        expect_eq("rst_tvalid", m_if.tvalid, 1'b0);
        expect_eq("rst_tdata", m_if.tdata, 8'h00);
        expect_eq("rst_tlast", m_if.tlast, 1'b0);
        expect_eq("rst_drop", drop, 16'd0);
        expect_eq("rst_busy", busy, 1'b0);
        expect_eq("s_tready", s_if.tready, 1'b1);
        expect_eq("m_tstrb", m_if.tstrb, 1'b1);
        rst_n = 1'b1;
        tick();

        run_frame(mk(8'hB2), 1'b0, 2, 1'b0, 1'b0, 8);
        expect_eq("busy_in_emit", busy, 1'b1);
        wait_frame(data, lat);
        expect_eq("basic_tdata", data, 8'hB2);
        expect_eq("basic_latency", lat, 1);
        expect_eq("basic_handshake", m_if.tvalid, 1'b0);
        expect_eq("basic_idle", busy, 1'b0);

        run_frame(mk(8'hB2), 1'b1, 2, 1'b0, 1'b0, 8);
        wait_frame(data, lat);
        expect_eq("pol_inv_tdata", data, 8'h4D);

        f = mk(8'hB2);
        f[4] = 100;  f[5] = -100;  f[6] = 50;  f[7] = -50;
        f[16] = 100; f[17] = -100; f[18] = 50; f[19] = -51;
        run_frame(f, 1'b0, 2, 1'b0, 1'b0, 8);
        wait_frame(data, lat);
        expect_eq("zero_sum_tdata", data, 8'hF2);

        run_frame(mk(8'hB2), 1'b0, 2, 1'b1, 1'b0, 8);
        wait_frame(data, lat);
        expect_eq("gap_tdata", data, 8'hB2);

        m_if.tready = 1'b0;
        run_frame(mk(8'hB2), 1'b0, 2, 1'b0, 1'b0, 8);
        drive(1'b0, 0);
        run_frame(mk(8'h5A), 1'b0, 2, 1'b0, 1'b0, 8);
        drive(1'b0, 0);
        drive(1'b0, 0);
        expect_eq("bp_tvalid", m_if.tvalid, 1'b1);
        expect_eq("bp_tdata_held", m_if.tdata, 8'hB2);
        expect_eq("bp_dropped", drop, 16'd1);
        m_if.tready = 1'b1;
        tick();
        expect_eq("bp_release", m_if.tvalid, 1'b0);

        run_frame(mk(8'hB2), 1'b0, 2, 1'b0, 1'b0, 3);
        #2 rst_n = 1'b0;
        #1;
        expect_eq("midrst_tvalid", m_if.tvalid, 1'b0);
        expect_eq("midrst_tdata", m_if.tdata, 8'h00);
        expect_eq("midrst_busy", busy, 1'b0);
        expect_eq("midrst_drop", drop, 16'd0);
        tick();
        rst_n = 1'b1;
        tick();
        run_frame(mk(8'h6C), 1'b0, 3, 1'b0, 1'b0, 8);
        wait_frame(data, lat);
        expect_eq("post_rst_tdata", data, 8'h6C);

        run_frame(mk(8'hB2), 1'b0, 2, 1'b0, 1'b1, 8);
        wait_frame(data, lat);
        expect_eq("retrig_tdata", data, 8'hB2);
        expect_eq("retrig_idle", busy, 1'b0);

        trig1 = 2'b01;
        drive(1'b0, 0);
        trig1 = 2'b00;
        data = 8'hB2;
        for (int k = 7; k >= 0; k--) drive(1'b1, data[k] ? 50 : -50);
        drive(1'b0, 0);
        lat = 0;
        while (!m1_if.tvalid && lat < 20) begin
            tick();
            lat++;
        end
        expect_eq("sps1_tvalid", m1_if.tvalid, 1'b1);
        expect_eq("sps1_tdata", m1_if.tdata, 8'hB2);
        expect_eq("sps1_latency", lat, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
